mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage responder for the decoder's mem_read/mem_write/funct3 controls. Turns one load or store
//  into a single req/ack transaction on the data-memory bus, with byte enables, store-lane replication
//  and load sign/zero extension. Holds `stall` until the access completes.
//  Sits between the EX/MEM pipeline register and the data memory. Feeds load_data to the MEM/WB register.
// PARAMETERS
//  ADDR_WIDTH   32   byte-address width of addr/bus_addr
//  TIMEOUT      255  max cycles waiting for bus_ack before aborting with bus_err (8-bit counter)
// PORTS
//  clk          in   1   single clock, all state updates on posedge
//  rst_n        in   1   reset, asynchronous, active-low
//  mem_read     in   2   2'b01 = load this cycle, else none
//  mem_write    in   2   2'b01 = store this cycle, else none
//  funct3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr         in   32  byte address from ALU
//  store_data   in   32  rs2 value
//  load_data    out  32  extended load result, registered, valid in DONE
//  stall        out  1   freeze IF..EX/MEM; high while access pending
//  misaligned   out  1   1-cycle pulse: H/HU with addr[0]!=0, or W with addr[1:0]!=0
//  bus_err      out  1   1-cycle pulse in DONE when access ended by timeout
//  bus_req      out  1   transaction request, held until ack
//  bus_we       out  1   1 = write
//  bus_addr     out  32  {addr[31:2],2'b00}
//  bus_wdata    out  32  lane-replicated store data
//  bus_be       out  4   byte enables
//  bus_rdata    in   32  read word, sampled with bus_ack
//  bus_ack      in   1   completes the transaction in the cycle it is sampled high with bus_req
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, counter 0. All outputs 0: load_data, stall, flags, bus_*.
//   Aborts any in-flight request immediately; bus_req drops without waiting for ack.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: access = mem_write==01 || mem_read==01. If both are set, the store wins.
//   Misaligned access: misaligned=1 for this cycle only, stall=0, no bus activity, state stays IDLE.
//   Aligned access: stall=1 (combinational, same cycle), latch we/addr/funct3/data/be, go to BUSY.
//  BUSY: bus_req=1 and bus_* outputs come from the latched values; stall=1; counter increments each cycle.
//   bus_ack=1: latch extended bus_rdata (loads only), go to DONE.
//   Counter reaches TIMEOUT without ack: drop bus_req, load_data=0, set bus_err, go to DONE.
//  DONE: stall=0 and bus_req=0, so the pipeline advances at the end of this cycle.
//   Inputs are ignored (they still show the old instruction). Go to IDLE unconditionally.
//  Latency: ack in the first BUSY cycle -> stall high for exactly 2 cycles, data valid in the 3rd.
//  Loads: lane = addr[1:0]. B/BU select byte lane, H/HU select half lane addr[1].
//   Sign-extend for funct3[2]=0, zero-extend for funct3[2]=1. funct3 011/110/111 are treated as W.
//  Stores: SB wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}}, be=4'b0011<<{addr[1],1'b0};
//   SW wdata=d, be=4'b1111. For loads, bus_be=4'b1111 and bus_we=0.
//  load_data holds its value after DONE until the next load completes. Stores do not modify it.
// STRUCTURE
//  Shared in ./constants/encordings.v: MEM_ACCESS (2'b01), funct3 size codes (F3_LB..F3_LHU, F3_SB..F3_SW),
//   FSM state encodings (MAU_IDLE/BUSY/DONE).
//  One sub-module: load_extender (combinational lane select + sign/zero extend), reused by the testbench model.
// TESTING
//  1 LW addr=0x100, ack on 1st BUSY cycle, rdata=0xDEADBEEF -> stall high 2 cycles, load_data=0xDEADBEEF, bus_be=1111
//  2 LB addr=0x103, rdata=0x80FF_FFFF -> load_data=0xFFFFFF80; LBU same -> 0x00000080
//  3 SH addr=0x202, d=0x1234ABCD -> bus_we=1, bus_addr=0x200, be=1100, wdata=0xABCDABCD; load_data unchanged
//  4 LW addr=0x101 -> misaligned pulse 1 cycle, stall=0, bus_req never asserted
//  5 LH, ack never arrives (TIMEOUT=4) -> bus_req high 4 cycles, then DONE with bus_err=1, load_data=0
//  6 rst_n low mid-BUSY (ack delayed 5) -> bus_req/stall drop asynchronously; after release a new SW completes normally
//  7 mem_read=mem_write=01 together -> a store is issued (bus_we=1); back-to-back LW/SW each get exactly one transaction

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: access strobe, funct3 codes,
// FSM states and the size/lane helpers used by the unit and its load extender.
package mem_access_unit_pkg;

    localparam logic [1:0] MEM_ACCESS = 2'b01;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUSY = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_e;

    // Unlisted load codes (011/110/111) fall through to a word access.
    function automatic access_size_e load_size(input logic [2:0] f3);
        access_size_e sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_B;
            F3_LH, F3_LHU: sz = SZ_H;
            F3_LW:         sz = SZ_W;
            default:       sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic access_size_e store_size(input logic [2:0] f3);
        access_size_e sz;
        case (f3)
            F3_SB:   sz = SZ_B;
            F3_SH:   sz = SZ_H;
            F3_SW:   sz = SZ_W;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] lane);
        logic mis;
        case (sz)
            SZ_H:    mis = lane[0];
            SZ_W:    mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input access_size_e sz, input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input access_size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Load lane select and sign/zero extension of a 32-bit read word.
module load_extender
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_en;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        sign_en  = ~funct3[2];
        data     = rdata;
        case (load_size(funct3))
            SZ_B:    data = {{24{byte_sel[7] & sign_en}}, byte_sel};
            SZ_H:    data = {{16{half_sel[15] & sign_en}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: one req/ack bus transaction per access,
// with byte enables, store lane replication, load extension and pipeline stall.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  MAU_IDLE | waiting for mem_read/mem_write; misaligned access pulses flag
//  MAU_BUSY | bus_req held from latched request until ack or timeout
//  MAU_DONE | result visible, stall released, returns to IDLE next cycle
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mem_read,
    input  logic [1:0]            mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic [31:0]           load_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_be,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mau_state_e            state_q, state_d;
    logic [7:0]            cnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            f3_q;
    logic [1:0]            lane_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  err_q;

    logic                  is_store;
    logic                  access_req;
    access_size_e          req_size;
    logic                  req_mis;
    logic                  issue;
    logic                  busy;
    logic                  timed_out;
    logic [31:0]           ext_data;

    assign is_store   = (mem_write == MEM_ACCESS);
    assign access_req = is_store || (mem_read == MEM_ACCESS);
    assign req_size   = is_store ? store_size(funct3) : load_size(funct3);
    assign req_mis    = is_misaligned(req_size, addr[1:0]);
    assign busy       = (state_q == MAU_BUSY);
    assign timed_out  = (cnt_q == CNT_LAST);

    load_extender u_load_extender (
        .funct3 (f3_q),
        .lane   (lane_q),
        .rdata  (bus_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MAU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, timeout counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            f3_q      <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            load_data <= '0;
        end else begin
            case (state_q)
                MAU_IDLE: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                    if (issue) begin
                        we_q    <= is_store;
                        addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        f3_q    <= funct3;
                        lane_q  <= addr[1:0];
                        wdata_q <= is_store ? store_wdata(req_size, store_data) : 32'h0;
                        be_q    <= is_store ? store_be(req_size, addr[1:0]) : 4'b1111;
                    end
                end
                MAU_BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (bus_ack) begin
                        if (!we_q) begin
                            load_data <= ext_data;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        if (!we_q) begin
                            load_data <= '0;
                        end
                    end
                end
                default: begin
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall and misaligned are gated by rst_n so every output reads 0 during reset.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        issue      = 1'b0;
        case (state_q)
            MAU_IDLE: begin
                if (access_req && rst_n) begin
                    if (req_mis) begin
                        misaligned = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        issue   = 1'b1;
                        state_d = MAU_BUSY;
                    end
                end
            end
            MAU_BUSY: begin
                stall = 1'b1;
                if (bus_ack || timed_out) begin
                    state_d = MAU_DONE;
                end
            end
            MAU_DONE: begin
                state_d = MAU_IDLE;
            end
            default: begin
                state_d = MAU_IDLE;
            end
        endcase
    end

    assign bus_req   = busy;
    assign bus_we    = busy & we_q;
    assign bus_addr  = busy ? addr_q  : '0;
    assign bus_wdata = busy ? wdata_q : '0;
    assign bus_be    = busy ? be_q    : '0;
    assign bus_err   = (state_q == MAU_DONE) & err_q;

endmodule
